// File: rtl/apb_master.sv
// APB initiator: turns single-beat requests into SETUP/ACCESS transfers to a
// GPIO (PSEL1) or UART (PSEL2) slave, with an optional ACCESS-phase timeout.
module apb_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_sel,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL1,
  output logic                  PSEL2,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA1,
  input  logic [DATA_WIDTH-1:0] PRDATA2,
  input  logic                  PREADY1,
  input  logic                  PREADY2
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  state_t                state_q, state_d;
  logic                  sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  psel1_q, psel1_d;
  logic                  psel2_q, psel2_d;
  logic                  penable_q, penable_d;
  logic                  reqReady_q, reqReady_d;
  logic                  rspValid_q, rspValid_d;
  logic [DATA_WIDTH-1:0] rspRdata_q, rspRdata_d;
  logic                  rspErr_q, rspErr_d;

  logic                  slvReady;
  logic [DATA_WIDTH-1:0] slvRdata;
  logic [7:0]            cntInc;

  // Only the slave captured at request time is observed; the counter
  // saturates so a disabled timeout can wait indefinitely without wrapping.
  always_comb begin
    slvReady = sel_q ? PREADY2 : PREADY1;
    slvRdata = sel_q ? PRDATA2 : PRDATA1;
    cntInc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    cnt_d      = cnt_q;
    psel1_d    = psel1_q;
    psel2_d    = psel2_q;
    penable_d  = penable_q;
    reqReady_d = reqReady_q;
    rspValid_d = 1'b0;
    rspRdata_d = rspRdata_q;
    rspErr_d   = rspErr_q;

    case (state_q)
      IDLE: begin
        reqReady_d = 1'b1;
        if (req_valid) begin
          state_d    = SETUP;
          sel_d      = req_sel;
          paddr_d    = req_addr;
          pwrite_d   = req_write;
          pwdata_d   = req_wdata;
          cnt_d      = 8'd0;
          psel1_d    = ~req_sel;
          psel2_d    = req_sel;
          penable_d  = 1'b0;
          reqReady_d = 1'b0;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        if (slvReady) begin
          state_d    = IDLE;
          psel1_d    = 1'b0;
          psel2_d    = 1'b0;
          penable_d  = 1'b0;
          reqReady_d = 1'b1;
          rspValid_d = 1'b1;
          rspRdata_d = pwrite_q ? '0 : slvRdata;
          rspErr_d   = 1'b0;
        end else begin
          cnt_d = cntInc;
          // Abort on the TIMEOUT-th low-PREADY edge, so ACCESS lasts TIMEOUT cycles.
          if ((TIMEOUT != 0) && (cntInc == TimeoutVal)) begin
            state_d    = IDLE;
            psel1_d    = 1'b0;
            psel2_d    = 1'b0;
            penable_d  = 1'b0;
            reqReady_d = 1'b1;
            rspValid_d = 1'b1;
            rspRdata_d = '0;
            rspErr_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        psel1_d    = 1'b0;
        psel2_d    = 1'b0;
        penable_d  = 1'b0;
        reqReady_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      cnt_q      <= 8'd0;
      psel1_q    <= 1'b0;
      psel2_q    <= 1'b0;
      penable_q  <= 1'b0;
      reqReady_q <= 1'b1;
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      cnt_q      <= cnt_d;
      psel1_q    <= psel1_d;
      psel2_q    <= psel2_d;
      penable_q  <= penable_d;
      reqReady_q <= reqReady_d;
      rspValid_q <= rspValid_d;
      rspRdata_q <= rspRdata_d;
      rspErr_q   <= rspErr_d;
    end
  end

  assign req_ready = reqReady_q;
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
  assign rsp_err   = rspErr_q;
  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: one instance with TIMEOUT=4 for the main
// scenarios, a second with TIMEOUT=0 for the long-wait no-abort case.
module tb_apb_master;

  logic       clk;
  logic       rst;
  logic       reqValid, reqReady, reqSel, reqWrite;
  logic [7:0] reqAddr, reqWdata;
  logic       rspValid, rspErr;
  logic [7:0] rspRdata;
  logic       psel1, psel2, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata1, prdata2;
  logic       pready1, pready2;

  logic       reqValid0, reqReady0, reqSel0, reqWrite0;
  logic [7:0] reqAddr0, reqWdata0;
  logic       rspValid0, rspErr0;
  logic [7:0] rspRdata0;
  logic       psel1x0, psel2x0, penable0, pwrite0;
  logic [7:0] paddr0, pwdata0;
  logic [7:0] prdata1x0, prdata2x0;
  logic       pready1x0, pready2x0;

  int checks = 0;
  int errors = 0;
  logic sawRsp0;

  apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(4)) dut (
    .PCLK(clk), .PRESET(rst),
    .req_valid(reqValid), .req_ready(reqReady), .req_sel(reqSel),
    .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rspValid), .rsp_rdata(rspRdata), .rsp_err(rspErr),
    .PSEL1(psel1), .PSEL2(psel2), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata),
    .PRDATA1(prdata1), .PRDATA2(prdata2), .PREADY1(pready1), .PREADY2(pready2)
  );

  apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(0)) dut0 (
    .PCLK(clk), .PRESET(rst),
    .req_valid(reqValid0), .req_ready(reqReady0), .req_sel(reqSel0),
    .req_write(reqWrite0), .req_addr(reqAddr0), .req_wdata(reqWdata0),
    .rsp_valid(rspValid0), .rsp_rdata(rspRdata0), .rsp_err(rspErr0),
    .PSEL1(psel1x0), .PSEL2(psel2x0), .PENABLE(penable0), .PADDR(paddr0),
    .PWRITE(pwrite0), .PWDATA(pwdata0),
    .PRDATA1(prdata1x0), .PRDATA2(prdata2x0), .PREADY1(pready1x0), .PREADY2(pready2x0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic w,
                               input logic [7:0] a, input logic [7:0] d);
    reqValid = v;
    reqSel   = s;
    reqWrite = w;
    reqAddr  = a;
    reqWdata = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    prdata1 = 8'h00; prdata2 = 8'h00; pready1 = 1'b0; pready2 = 1'b0;
    reqValid0 = 1'b0; reqSel0 = 1'b0; reqWrite0 = 1'b0; reqAddr0 = 8'h00; reqWdata0 = 8'h00;
    prdata1x0 = 8'h00; prdata2x0 = 8'h00; pready1x0 = 1'b0; pready2x0 = 1'b0;
    sawRsp0 = 1'b0;

    // Reset values
    step(); step();
    checkOutput("rst_req_ready", reqReady, 1);
    checkOutput("rst_psel1", psel1, 0);
    checkOutput("rst_psel2", psel2, 0);
    checkOutput("rst_penable", penable, 0);
    checkOutput("rst_paddr", paddr, 0);
    checkOutput("rst_pwdata", pwdata, 0);
    checkOutput("rst_pwrite", pwrite, 0);
    checkOutput("rst_rsp_valid", rspValid, 0);
    checkOutput("rst_req_ready0", reqReady0, 1);
    rst = 1'b0;
    step();

    // UART write, zero-wait slave
    $display("[TB] UART write");
    pready2 = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h2A);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("w_setup_psel2", psel2, 1);
    checkOutput("w_setup_psel1", psel1, 0);
    checkOutput("w_setup_penable", penable, 0);
    checkOutput("w_setup_pwdata", pwdata, 8'h2A);
    checkOutput("w_setup_pwrite", pwrite, 1);
    checkOutput("w_setup_req_ready", reqReady, 0);
    step();
    checkOutput("w_access_psel2", psel2, 1);
    checkOutput("w_access_penable", penable, 1);
    checkOutput("w_access_psel1", psel1, 0);
    checkOutput("w_access_rsp_valid", rspValid, 0);
    step();
    checkOutput("w_rsp_valid", rspValid, 1);
    checkOutput("w_rsp_rdata", rspRdata, 0);
    checkOutput("w_rsp_err", rspErr, 0);
    checkOutput("w_rsp_req_ready", reqReady, 1);
    checkOutput("w_rsp_psel2", psel2, 0);
    checkOutput("w_rsp_penable", penable, 0);
    step();
    checkOutput("w_rsp_pulse_end", rspValid, 0);

    // GPIO read with 3 wait cycles; UART signals must be ignored
    $display("[TB] GPIO read with waits");
    pready1 = 1'b0; prdata1 = 8'hA5; prdata2 = 8'hFF; pready2 = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h04, 8'h00);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("r_setup_psel1", psel1, 1);
    checkOutput("r_setup_psel2", psel2, 0);
    checkOutput("r_setup_paddr", paddr, 8'h04);
    checkOutput("r_setup_pwrite", pwrite, 0);
    step();
    checkOutput("r_access1_penable", penable, 1);
    step(); step(); step();
    checkOutput("r_access4_penable", penable, 1);
    checkOutput("r_access4_psel1", psel1, 1);
    checkOutput("r_access4_rsp_valid", rspValid, 0);
    pready1 = 1'b1;
    step();
    checkOutput("r_rsp_valid", rspValid, 1);
    checkOutput("r_rsp_rdata", rspRdata, 8'hA5);
    checkOutput("r_rsp_err", rspErr, 0);
    pready1 = 1'b0; pready2 = 1'b0;
    step();

    // UART read timeout with TIMEOUT=4
    $display("[TB] UART timeout");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(); step(); step(); step();
    checkOutput("t_access4_penable", penable, 1);
    checkOutput("t_access4_psel2", psel2, 1);
    checkOutput("t_access4_rsp_valid", rspValid, 0);
    step();
    checkOutput("t_rsp_valid", rspValid, 1);
    checkOutput("t_rsp_err", rspErr, 1);
    checkOutput("t_rsp_rdata", rspRdata, 0);
    checkOutput("t_req_ready", reqReady, 1);
    checkOutput("t_psel2", psel2, 0);
    checkOutput("t_penable", penable, 0);
    step();

    // Back-to-back requests with req_valid held
    $display("[TB] Back-to-back");
    pready1 = 1'b1; prdata1 = 8'h3C;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
    step();
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h30, 8'h55);
    checkOutput("b_setup_req_ready", reqReady, 0);
    checkOutput("b_setup_paddr", paddr, 8'h20);
    step();
    checkOutput("b_access_req_ready", reqReady, 0);
    checkOutput("b_access_paddr", paddr, 8'h20);
    checkOutput("b_access_pwrite", pwrite, 0);
    step();
    checkOutput("b_rsp1_valid", rspValid, 1);
    checkOutput("b_rsp1_rdata", rspRdata, 8'h3C);
    checkOutput("b_rsp1_req_ready", reqReady, 1);
    checkOutput("b_rsp1_paddr", paddr, 8'h20);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("b_setup2_paddr", paddr, 8'h30);
    checkOutput("b_setup2_pwrite", pwrite, 1);
    checkOutput("b_setup2_pwdata", pwdata, 8'h55);
    checkOutput("b_setup2_psel1", psel1, 1);
    checkOutput("b_setup2_penable", penable, 0);
    checkOutput("b_setup2_rsp_valid", rspValid, 0);
    step();
    step();
    checkOutput("b_rsp2_valid", rspValid, 1);
    checkOutput("b_rsp2_rdata", rspRdata, 0);
    pready1 = 1'b0;
    step();

    // Reset during ACCESS with wait states
    $display("[TB] Reset mid-transfer");
    pready2 = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h40, 8'h00);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(); step();
    checkOutput("x_access_penable", penable, 1);
    rst = 1'b1;
    step();
    checkOutput("x_psel2", psel2, 0);
    checkOutput("x_penable", penable, 0);
    checkOutput("x_paddr", paddr, 0);
    checkOutput("x_rsp_valid", rspValid, 0);
    checkOutput("x_req_ready", reqReady, 1);
    rst = 1'b0;
    step(); step(); step(); step();
    checkOutput("x_no_late_rsp", rspValid, 0);
    pready1 = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h44, 8'h99);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("x_new_paddr", paddr, 8'h44);
    checkOutput("x_new_pwdata", pwdata, 8'h99);
    step(); step();
    checkOutput("x_new_rsp_valid", rspValid, 1);
    checkOutput("x_new_rsp_err", rspErr, 0);
    pready1 = 1'b0;
    step();

    // TIMEOUT=0: 300 wait cycles, no abort
    $display("[TB] Timeout disabled");
    prdata1x0 = 8'h5A; pready1x0 = 1'b0;
    reqValid0 = 1'b1; reqSel0 = 1'b0; reqWrite0 = 1'b0; reqAddr0 = 8'h08;
    step();
    reqValid0 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (rspValid0) sawRsp0 = 1'b1;
    end
    checkOutput("z_no_abort", sawRsp0, 0);
    checkOutput("z_penable_held", penable0, 1);
    checkOutput("z_psel1_held", psel1x0, 1);
    pready1x0 = 1'b1;
    step();
    checkOutput("z_rsp_valid", rspValid0, 1);
    checkOutput("z_rsp_err", rspErr0, 0);
    checkOutput("z_rsp_rdata", rspRdata0, 8'h5A);
    checkOutput("z_req_ready", reqReady0, 1);
    pready1x0 = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
